// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared widths and capture FSM state type for the frame capture slice
package cam_pkg;
    localparam int DATA_W = 10;
    localparam int CNT_W  = 12;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SOF,
        CAP,
        DRAIN
    } capture_state_t;
endpackage

// File: rtl/frame_capture_ctrl_if.sv
// rtl/frame_capture_ctrl_if.sv - camera pixel stream in, window pixel write port out
interface frame_capture_ctrl_if #(
    parameter int DATA_W = cam_pkg::DATA_W
);
    logic              fv;
    logic              lv;
    logic              pix_en;
    logic [DATA_W-1:0] pix_data;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              wr_ready;

    modport master (
        input  fv, lv, pix_en, pix_data, wr_ready,
        output wr_valid, wr_data, wr_last
    );

    modport slave (
        output fv, lv, pix_en, pix_data, wr_ready,
        input  wr_valid, wr_data, wr_last
    );
endinterface

// File: rtl/pixel_window_counter.sv
// rtl/pixel_window_counter.sv - registers the camera stream, tracks col/row and flags window pixels
module pixel_window_counter #(
    parameter int DATA_W = cam_pkg::DATA_W,
    parameter int CNT_W  = cam_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fv,
    input  logic              lv,
    input  logic              pix_en,
    input  logic [DATA_W-1:0] pix_data,
    input  logic [CNT_W-1:0]  x0,
    input  logic [CNT_W-1:0]  y0,
    input  logic [CNT_W-1:0]  w,
    input  logic [CNT_W-1:0]  h,
    output logic              fv_lvl,
    output logic              fv_rise,
    output logic              fv_fall,
    output logic              px_vld,
    output logic              px_last,
    output logic [DATA_W-1:0] px_data
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] ONE     = 1;
    localparam logic [CNT_W:0]   ONE_E   = 1;

    logic              fv_r_q, fv_r_d, lv_r_q, lv_r_d, pen_r_q, pen_r_d;
    logic              fv_p_q, fv_p_d, lv_p_q, lv_p_d;
    logic [DATA_W-1:0] dat_r_q, dat_r_d;
    logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
    logic              line_pix_q, line_pix_d;
    logic              px_vld_q, px_vld_d, px_last_q, px_last_d;
    logic [DATA_W-1:0] px_data_q, px_data_d;

    logic              lv_fall, pix, in_x, in_y;
    logic [CNT_W:0]    col_e, row_e, x_end, y_end;

    always_comb begin
        fv_r_d     = fv;
        lv_r_d     = lv;
        pen_r_d    = pix_en;
        dat_r_d    = pix_data;
        fv_p_d     = fv_r_q;
        lv_p_d     = lv_r_q;
        col_d      = col_q;
        row_d      = row_q;
        line_pix_d = line_pix_q;

        fv_rise = fv_r_q & ~fv_p_q;
        fv_fall = ~fv_r_q & fv_p_q;
        lv_fall = ~lv_r_q & lv_p_q;
        pix     = pen_r_q & lv_r_q & fv_r_q;

        // One extra bit on the window ends so x0+w never wraps
        col_e = {1'b0, col_q};
        row_e = {1'b0, row_q};
        x_end = {1'b0, x0} + {1'b0, w};
        y_end = {1'b0, y0} + {1'b0, h};
        in_x  = (col_e >= {1'b0, x0}) && (col_e < x_end);
        in_y  = (row_e >= {1'b0, y0}) && (row_e < y_end);

        px_vld_d  = pix & in_x & in_y;
        px_last_d = (col_e == x_end - ONE_E) && (row_e == y_end - ONE_E);
        px_data_d = dat_r_q;

        if (pix) begin
            col_d      = (col_q == CNT_MAX) ? col_q : col_q + ONE;
            line_pix_d = 1'b1;
        end
        if (lv_fall) begin
            col_d      = '0;
            line_pix_d = 1'b0;
            if (line_pix_q) row_d = (row_q == CNT_MAX) ? row_q : row_q + ONE;
        end
        if (fv_rise) begin
            col_d      = '0;
            row_d      = '0;
            line_pix_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fv_r_q     <= 1'b0;
            lv_r_q     <= 1'b0;
            pen_r_q    <= 1'b0;
            dat_r_q    <= '0;
            fv_p_q     <= 1'b0;
            lv_p_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            line_pix_q <= 1'b0;
            px_vld_q   <= 1'b0;
            px_last_q  <= 1'b0;
            px_data_q  <= '0;
        end else begin
            fv_r_q     <= fv_r_d;
            lv_r_q     <= lv_r_d;
            pen_r_q    <= pen_r_d;
            dat_r_q    <= dat_r_d;
            fv_p_q     <= fv_p_d;
            lv_p_q     <= lv_p_d;
            col_q      <= col_d;
            row_q      <= row_d;
            line_pix_q <= line_pix_d;
            px_vld_q   <= px_vld_d;
            px_last_q  <= px_last_d;
            px_data_q  <= px_data_d;
        end
    end

    assign fv_lvl  = fv_r_q;
    assign px_vld  = px_vld_q;
    assign px_last = px_last_q;
    assign px_data = px_data_q;
endmodule

// File: rtl/frame_capture_ctrl.sv
// rtl/frame_capture_ctrl.sv - single-frame window capture sequencer with one-entry output register
module frame_capture_ctrl #(
    parameter int DATA_W = cam_pkg::DATA_W,
    parameter int CNT_W  = cam_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     cfg_x0,
    input  logic [CNT_W-1:0]     cfg_y0,
    input  logic [CNT_W-1:0]     cfg_w,
    input  logic [CNT_W-1:0]     cfg_h,
    frame_capture_ctrl_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 short_frame
);
    import cam_pkg::*;

    capture_state_t    state_q, state_d;
    logic [CNT_W-1:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
    logic              wr_valid_q, wr_valid_d, wr_last_q, wr_last_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d, ovf_q, ovf_d, short_q, short_d;

    logic              fv_lvl, fv_rise, fv_fall, px_vld, px_last, accept;
    logic [DATA_W-1:0] px_data;

    pixel_window_counter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .fv      (bus.fv),
        .lv      (bus.lv),
        .pix_en  (bus.pix_en),
        .pix_data(bus.pix_data),
        .x0      (x0_q),
        .y0      (y0_q),
        .w       (w_q),
        .h       (h_q),
        .fv_lvl  (fv_lvl),
        .fv_rise (fv_rise),
        .fv_fall (fv_fall),
        .px_vld  (px_vld),
        .px_last (px_last),
        .px_data (px_data)
    );

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        wr_valid_d = wr_valid_q;
        wr_data_d  = wr_data_q;
        wr_last_d  = wr_last_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        short_d    = short_q;
        accept     = wr_valid_q & bus.wr_ready;

        if (accept) begin
            wr_valid_d = 1'b0;
            wr_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: if (start) begin
                x0_d    = cfg_x0;
                y0_d    = cfg_y0;
                w_d     = cfg_w;
                h_d     = cfg_h;
                ovf_d   = 1'b0;
                short_d = 1'b0;
                state_d = (cfg_w == '0 || cfg_h == '0) ? DRAIN : ARM;
            end
            ARM: if (!fv_lvl) state_d = SOF;
            SOF: if (fv_rise) state_d = CAP;
            CAP: begin
                if (px_vld) begin
                    // A dropped last pixel still ends the window, just without wr_last
                    if (!wr_valid_q || accept) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = px_data;
                        wr_last_d  = px_last;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (px_last) state_d = DRAIN;
                end else if (fv_fall) begin
                    short_d = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: if (!wr_valid_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d    = IDLE;
            x0_d       = x0_q;
            y0_d       = y0_q;
            w_d        = w_q;
            h_d        = h_q;
            wr_valid_d = 1'b0;
            wr_last_d  = 1'b0;
            done_d     = 1'b0;
            ovf_d      = ovf_q;
            short_d    = short_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            wr_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_last_q  <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
            wr_last_q  <= wr_last_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            short_q    <= short_d;
        end
    end

    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_last  = wr_last_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign short_frame  = short_q;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// tb/tb_frame_capture_ctrl.sv - directed bench: scaled bar camera (128x16, 32-px bars) feeding frame_capture_ctrl
module tb_frame_capture_ctrl;
    import cam_pkg::*;

    localparam int FW = 128, FH = 16, VB = 20, HB = 6;
    localparam int MAXW = 8000;

    logic             clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] cfg_x0 = '0, cfg_y0 = '0, cfg_w = '0, cfg_h = '0;
    logic             busy, done, overflow, short_frame;

    frame_capture_ctrl_if bus ();

    frame_capture_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .cfg_x0     (cfg_x0),
        .cfg_y0     (cfg_y0),
        .cfg_w      (cfg_w),
        .cfg_h      (cfg_h),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .short_frame(short_frame)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int n_wr, n_last, last_idx, n_done, n_bad, m_x0, m_y0, m_w, cam_row, k;
    bit chk_data = 1'b0;
    logic [DATA_W-1:0] first_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bars in the low bits, row number in bits [9:6] so row misplacement is visible
    function automatic logic [DATA_W-1:0] pix_val(input int c, input int r);
        int v;
        v = ((r & 15) << 6) | ((((c >> 5) & 1) != 0) ? 32'h20 : 32'h00);
        return DATA_W'(v);
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.fv = 1'b0; bus.lv = 1'b0; bus.pix_en = 1'b0; bus.pix_data = '0;
        cam_row = -1;
        forever begin
            repeat (VB) step();
            bus.fv = 1'b1;
            step(3);
            for (int r = 0; r < FH; r++) begin
                cam_row = r; bus.lv = 1'b1; bus.pix_en = 1'b1;
                for (int c = 0; c < FW; c++) begin
                    bus.pix_data = pix_val(c, r);
                    step();
                end
                bus.lv = 1'b0; bus.pix_en = 1'b0;
                step(HB);
            end
            cam_row = -1;
            step(3);
            bus.fv = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.wr_valid && bus.wr_ready) begin
            if (n_wr == 0) first_data = bus.wr_data;
            if (chk_data) begin
                if (bus.wr_data !== pix_val(m_x0 + n_wr % m_w, m_y0 + n_wr / m_w)) n_bad++;
            end
            if (bus.wr_last) begin
                n_last++;
                last_idx = n_wr;
            end
            n_wr++;
        end
        if (done) n_done++;
    end

    task automatic do_start(input int x0, input int y0, input int w, input int h, input bit chk);
        cfg_x0 = CNT_W'(x0); cfg_y0 = CNT_W'(y0); cfg_w = CNT_W'(w); cfg_h = CNT_W'(h);
        m_x0 = x0; m_y0 = y0; m_w = w; chk_data = chk;
        n_wr = 0; n_last = 0; last_idx = -1; n_done = 0; n_bad = 0; first_data = '1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        k = 0;
        while (n_done == 0 && k < max) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_done_seen"}, 32'(n_done != 0), 1);
        step(4);
        check_eq({tag, "_done_once"}, n_done, 1);
        check_eq({tag, "_busy_low"}, busy, 0);
    endtask

    task automatic wait_row(input int r);
        k = 0;
        while (!(cam_row == r && bus.lv) && k < MAXW) begin
            step();
            k++;
        end
        check_eq("row_reached", 32'(k < MAXW), 1);
    endtask

    initial begin
        bus.wr_ready = 1'b1;
        step(3);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_short", short_frame, 0);
        check_eq("rst_wr_valid", bus.wr_valid, 0);
        check_eq("rst_wr_last", bus.wr_last, 0);
        step();

        do_start(0, 0, 0, 16, 0);
        wait_done("zero_w", 50);
        check_eq("zero_w_writes", n_wr, 0);

        do_start(0, 0, FW, FH, 1);
        wait_done("full", MAXW);
        check_eq("full_writes", n_wr, FW * FH);
        check_eq("full_last_cnt", n_last, 1);
        check_eq("full_last_idx", last_idx, FW * FH - 1);
        check_eq("full_data_bad", n_bad, 0);
        check_eq("full_overflow", overflow, 0);
        check_eq("full_short", short_frame, 0);

        // A second start mid-capture with different cfg must be ignored
        do_start(32, 10, 32, 2, 1);
        step(100);
        cfg_w = 1; cfg_h = 1; start = 1'b1;
        step();
        start = 1'b0;
        wait_done("win", MAXW);
        check_eq("win_writes", n_wr, 64);
        check_eq("win_last_idx", last_idx, 63);
        check_eq("win_last_cnt", n_last, 1);
        check_eq("win_data_bad", n_bad, 0);
        check_eq("win_first_data", first_data, 10'h2A0);

        wait_row(8);
        do_start(0, 0, FW, FH, 1);
        wait_done("mid", MAXW);
        check_eq("mid_writes", n_wr, FW * FH);
        check_eq("mid_data_bad", n_bad, 0);
        check_eq("mid_last_idx", last_idx, FW * FH - 1);

        bus.wr_ready = 1'b0;
        do_start(0, 0, 4, 1, 0);
        k = 0;
        while (!bus.wr_valid && k < MAXW) begin
            @(negedge clk);
            k++;
        end
        check_eq("ovf_first_load", bus.wr_valid, 1);
        @(posedge clk);
        step();
        check_eq("ovf_hold_valid", bus.wr_valid, 1);
        check_eq("ovf_hold_data", bus.wr_data, pix_val(0, 0));
        bus.wr_ready = 1'b1;
        wait_done("ovf", 100);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_writes", n_wr, 2);
        check_eq("ovf_last_cnt", n_last, 1);
        check_eq("ovf_first_data", first_data, pix_val(0, 0));

        do_start(0, 0, FW, 20, 1);
        wait_done("tall", MAXW);
        check_eq("tall_writes", n_wr, FW * FH);
        check_eq("tall_last_cnt", n_last, 0);
        check_eq("tall_short", short_frame, 1);
        check_eq("tall_overflow", overflow, 0);

        do_start(0, 0, FW, FH, 1);
        wait_row(5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_wr_valid", bus.wr_valid, 0);
        check_eq("abort_wr_last", bus.wr_last, 0);
        check_eq("abort_short_kept", short_frame, 0);
        check_eq("abort_had_writes", 32'(n_wr > 0), 1);
        step(50);
        check_eq("abort_no_done", n_done, 0);

        do_start(0, 0, FW, FH, 1);
        wait_done("restart", MAXW);
        check_eq("restart_writes", n_wr, FW * FH);
        check_eq("restart_last_cnt", n_last, 1);
        check_eq("restart_data_bad", n_bad, 0);

        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check_eq("start_abort_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
